// File: rtl/instr_pkg.sv
// Shared instruction-set constants for the instruction path.
// Holds the descriptor kind encoding, the 6-bit MIPS opcodes and the R-type
// funct codes. The control decoder uses the same constants, so the loader and
// the decoder cannot drift apart.
package instr_pkg;

    // Descriptor kinds as presented on in_kind; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_LW   = 3'd1,
        KIND_SW   = 3'd2,
        KIND_BEQ  = 3'd3,
        KIND_ADDI = 3'd4,
        KIND_J    = 3'd5
    } kind_t;

    // Primary opcodes, bits [31:26] of the instruction word.
    localparam logic [5:0] ALU_R      = 6'h00;
    localparam logic [5:0] LOAD_WORD  = 6'h23;
    localparam logic [5:0] STORE_WORD = 6'h2B;
    localparam logic [5:0] BRANCH_EQ  = 6'h04;
    localparam logic [5:0] ADDI       = 6'h08;
    localparam logic [5:0] JUMP       = 6'h02;

    // R-type funct codes, bits [5:0] when the opcode is ALU_R.
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: descriptor kind plus fields -> 32-bit MIPS word.
// Ports:
//   kind     in  3   descriptor kind (instr_pkg::kind_t encoding)
//   rs/rt/rd/shamt in 5 each  register and shift fields
//   funct    in  6   R-type funct
//   imm      in  16  immediate / branch offset
//   target   in  26  jump target
//   word     out 32  encoded instruction (0 when illegal)
//   illegal  out 1   kind is not one of the six supported formats
module instr_word_pack
    import instr_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_R:    word = {ALU_R, rs, rt, rd, shamt, funct};
            KIND_LW:   word = {LOAD_WORD, rs, rt, imm};
            KIND_SW:   word = {STORE_WORD, rs, rt, imm};
            KIND_BEQ:  word = {BRANCH_EQ, rs, rt, imm};
            KIND_ADDI: word = {ADDI, rs, rt, imm};
            KIND_J:    word = {JUMP, target};
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: accepts decoded descriptors over valid/ready,
// packs each into a MIPS word and writes it at consecutive word addresses
// starting at BASE_ADDR.
// Optional feature macro: HALT_APPEND_EN -- when defined, a jump-to-self halt
// word is appended after the last descriptor (if there is room).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a new program (honoured only when idle)
//   in_valid/in_ready   descriptor handshake
//   in_kind..in_last    descriptor fields
//   mem_we/mem_addr/mem_wdata  registered instruction-memory write port
//   busy                program load or flush in progress
//   done                one-cycle completion pulse
//   word_count          words written since start
//   err                 sticky: illegal kind or overflow
module instr_mem_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);

    // HALT_WAIT/FINISH are only reached when the halt word is appended.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_HALT_WAIT,
        S_FINISH
    } state_t;

    state_t state, state_next;

    logic [31:0]       packed_word;
    logic              illegal;
    logic              full;
    logic              accept;
    logic              overflow;
    logic [ADDR_W-1:0] wr_addr;

    instr_word_pack u_pack (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .funct   (in_funct),
        .imm     (in_imm),
        .target  (in_target),
        .word    (packed_word),
        .illegal (illegal)
    );

    assign full     = (word_count >= MAX_CNT);
    assign in_ready = (state == S_LOAD) && !full;
    assign accept   = in_valid && in_ready;
    // A descriptor offered with no room left ends the program with an error.
    assign overflow = (state == S_LOAD) && in_valid && full;
    assign wr_addr  = BASE_A + word_count[ADDR_W-1:0];
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                if ((accept && in_last) || overflow) state_next = S_FLUSH;
            end
`ifdef HALT_APPEND_EN
            S_FLUSH:     state_next = S_HALT_WAIT;
            S_HALT_WAIT: state_next = S_FINISH;
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
`else
            S_FLUSH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

`ifdef HALT_APPEND_EN
    logic [25:0] halt_tgt;
    assign halt_tgt = 26'(BASE_ADDR) + 26'(word_count);
`endif

    // Write stage: descriptor accepted this cycle appears on the memory port next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if ((state == S_IDLE) && start) begin
                word_count <= '0;
                err        <= 1'b0;
            end
            if (accept) begin
                if (illegal) begin
                    err <= 1'b1;
                end else begin
                    mem_we     <= 1'b1;
                    mem_addr   <= wr_addr;
                    mem_wdata  <= packed_word;
                    word_count <= word_count + CNT_W'(1);
                end
            end
            if (overflow) err <= 1'b1;
`ifdef HALT_APPEND_EN
            // First flush cycle: append a jump-to-self so fetch parks after the program.
            if (state == S_FLUSH) begin
                if (!full) begin
                    mem_we     <= 1'b1;
                    mem_addr   <= wr_addr;
                    mem_wdata  <= {JUMP, halt_tgt};
                    word_count <= word_count + CNT_W'(1);
                end else begin
                    err <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam int NI = 2;
`ifdef HALT_APPEND_EN
    localparam int HALT_EXTRA = 1;
    localparam int FLUSH_LEN  = 3;
`else
    localparam int HALT_EXTRA = 0;
    localparam int FLUSH_LEN  = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_kind = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]  in_funct = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_last = 1'b0;

    logic        d0_ready, d0_we, d0_busy, d0_done, d0_err;
    logic [9:0]  d0_addr;
    logic [31:0] d0_wdata;
    logic [10:0] d0_cnt;
    logic        d1_ready, d1_we, d1_busy, d1_done, d1_err;
    logic [5:0]  d1_addr;
    logic [31:0] d1_wdata;
    logic [6:0]  d1_cnt;

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(1024)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(d0_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_we(d0_we), .mem_addr(d0_addr), .mem_wdata(d0_wdata), .busy(d0_busy),
        .done(d0_done), .word_count(d0_cnt), .err(d0_err)
    );

    instr_mem_loader #(.ADDR_W(6), .BASE_ADDR(16), .MAX_WORDS(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(d1_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_we(d1_we), .mem_addr(d1_addr), .mem_wdata(d1_wdata), .busy(d1_busy),
        .done(d1_done), .word_count(d1_cnt), .err(d1_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", name, inst, act, exp, $time);
        end
    endtask

    // Reference model: instruction encoding by opcode/field arithmetic.
    function automatic logic [31:0] enc(input int k, input int rs, input int rt, input int rd,
                                        input int sh, input int fn, input int imm, input int tgt);
        longint op, v;
        case (k)
            0: op = 0;
            1: op = 35;
            2: op = 43;
            3: op = 4;
            4: op = 8;
            default: op = 2;
        endcase
        if (k == 0)      v = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + sh * 64 + fn;
        else if (k == 5) v = tgt;
        else             v = longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
        return 32'(op * 67108864 + v);
    endfunction

    int base_a[NI] = '{0, 16};
    int maxw[NI]   = '{1024, 4};
    int aspace[NI] = '{1024, 64};

    // phase: 0 idle, 1 loading, 2 finishing (left = cycles until back to idle)
    int          m_phase[NI];
    int          m_left[NI];
    int          m_cnt[NI];
    bit          m_err[NI];
    bit          m_we[NI];
    int          m_addr[NI];
    logic [31:0] m_wdata[NI];
    bit          armed = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            m_we[i] = 1'b0;
            if (rst) begin
                m_phase[i] = 0; m_left[i] = 0; m_cnt[i] = 0; m_err[i] = 1'b0;
                m_addr[i] = 0; m_wdata[i] = '0;
                armed = 1'b1;
            end else if (m_phase[i] == 0) begin
                if (start) begin
                    m_phase[i] = 1; m_cnt[i] = 0; m_err[i] = 1'b0;
                end
            end else if (m_phase[i] == 1) begin
                if (in_valid) begin
                    if (m_cnt[i] < maxw[i]) begin
                        if (int'(in_kind) > 5) begin
                            m_err[i] = 1'b1;
                        end else begin
                            m_we[i]    = 1'b1;
                            m_addr[i]  = (base_a[i] + m_cnt[i]) % aspace[i];
                            m_wdata[i] = enc(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd),
                                             int'(in_shamt), int'(in_funct), int'(in_imm), int'(in_target));
                            m_cnt[i]++;
                        end
                        if (in_last) begin
                            m_phase[i] = 2; m_left[i] = FLUSH_LEN;
                        end
                    end else begin
                        m_err[i] = 1'b1;
                        m_phase[i] = 2; m_left[i] = FLUSH_LEN;
                    end
                end
            end else begin
`ifdef HALT_APPEND_EN
                if (m_left[i] == 3) begin
                    if (m_cnt[i] < maxw[i]) begin
                        m_we[i]    = 1'b1;
                        m_addr[i]  = (base_a[i] + m_cnt[i]) % aspace[i];
                        m_wdata[i] = 32'(2 * 67108864 + ((base_a[i] + m_cnt[i]) % 67108864));
                        m_cnt[i]++;
                    end else begin
                        m_err[i] = 1'b1;
                    end
                end
`endif
                m_left[i]--;
                if (m_left[i] == 0) m_phase[i] = 0;
            end
        end
    end

    task automatic cmp_inst(input int i, input logic we, input logic [31:0] ad, input logic [31:0] wd,
                            input logic rdy, input logic bsy, input logic dn, input logic [31:0] cnt,
                            input logic er);
        chk("mem_we", i, 64'(we), 64'(m_we[i]));
        chk("mem_addr", i, 64'(ad), 64'(m_addr[i]));
        chk("mem_wdata", i, 64'(wd), 64'(m_wdata[i]));
        chk("in_ready", i, 64'(rdy), 64'((m_phase[i] == 1) && (m_cnt[i] < maxw[i])));
        chk("busy", i, 64'(bsy), 64'(m_phase[i] != 0));
        chk("done", i, 64'(dn), 64'((m_phase[i] == 2) && (m_left[i] == 1)));
        chk("word_count", i, 64'(cnt), 64'(m_cnt[i]));
        chk("err", i, 64'(er), 64'(m_err[i]));
    endtask

    int          log_n[NI];
    int          log_ad[NI][8];
    logic [31:0] log_wd[NI][8];
    int          done_n[NI];

    // Per-cycle comparison against the model, plus a log of writes and done pulses.
    always @(negedge clk) begin
        if (armed) begin
            cmp_inst(0, d0_we, 32'(d0_addr), d0_wdata, d0_ready, d0_busy, d0_done, 32'(d0_cnt), d0_err);
            cmp_inst(1, d1_we, 32'(d1_addr), d1_wdata, d1_ready, d1_busy, d1_done, 32'(d1_cnt), d1_err);
            if (d0_we === 1'b1) begin
                if (log_n[0] < 8) begin log_ad[0][log_n[0]] = int'(d0_addr); log_wd[0][log_n[0]] = d0_wdata; end
                log_n[0]++;
            end
            if (d1_we === 1'b1) begin
                if (log_n[1] < 8) begin log_ad[1][log_n[1]] = int'(d1_addr); log_wd[1][log_n[1]] = d1_wdata; end
                log_n[1]++;
            end
            if (d0_done === 1'b1) done_n[0]++;
            if (d1_done === 1'b1) done_n[1]++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NI; i++) begin
            log_n[i] = 0;
            done_n[i] = 0;
        end
    endtask

    task automatic do_start();
        clear_logs();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input int k, input int rs, input int rt, input int rd, input int sh,
                        input int fn, input int imm, input int tgt, input bit last);
        in_valid = 1'b1; in_kind = 3'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (((d0_busy !== 1'b0) || (d1_busy !== 1'b0)) && k < 20) begin
            step();
            k++;
        end
        chk("idle_within_budget", 0, 64'(k < 20), 64'(1));
        step();
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_mem_we", 0, 64'(d0_we), 64'(0));
        chk("rst_in_ready", 0, 64'(d0_ready), 64'(0));
        chk("rst_busy", 0, 64'(d0_busy), 64'(0));
        chk("rst_count", 0, 64'(d0_cnt), 64'(0));
        rst = 1'b0;
        step();

        // Model encoding pinned to hand-computed words
        chk("enc_r", 0, 64'(enc(0, 1, 2, 3, 0, 32'h20, 0, 0)), 64'(32'h00221820));
        chk("enc_lw", 0, 64'(enc(1, 0, 8, 0, 0, 0, 4, 0)), 64'(32'h8C080004));
        chk("enc_sw", 0, 64'(enc(2, 0, 8, 0, 0, 0, 8, 0)), 64'(32'hAC080008));

        // 1: single R-type descriptor
        do_start();
        send(0, 1, 2, 3, 0, 32'h20, 0, 0, 1'b1);
        wait_idle();
        chk("t1_writes", 0, 64'(log_n[0]), 64'(1 + HALT_EXTRA));
        chk("t1_addr", 0, 64'(log_ad[0][0]), 64'(0));
        chk("t1_wdata", 0, 64'(log_wd[0][0]), 64'(32'h00221820));
        chk("t1_done", 0, 64'(done_n[0]), 64'(1));
        chk("t1_count", 0, 64'(d0_cnt), 64'(1 + HALT_EXTRA));

        // 2: LW then back-to-back SW
        do_start();
        send(1, 0, 8, 0, 0, 0, 4, 0, 1'b0);
        chk("t2_ready_mid", 0, 64'(d0_ready), 64'(1));
        send(2, 0, 8, 0, 0, 0, 8, 0, 1'b1);
        wait_idle();
        chk("t2_w0", 0, 64'(log_wd[0][0]), 64'(32'h8C080004));
        chk("t2_a1", 0, 64'(log_ad[0][1]), 64'(1));
        chk("t2_w1", 0, 64'(log_wd[0][1]), 64'(32'hAC080008));

        // 3: illegal kind between two ADDI
        do_start();
        send(4, 1, 2, 0, 0, 0, 5, 0, 1'b0);
        send(7, 3, 3, 3, 3, 3, 3, 3, 1'b0);
        send(4, 2, 3, 0, 0, 0, 16'hFFFF, 0, 1'b1);
        wait_idle();
        chk("t3_a1", 0, 64'(log_ad[0][1]), 64'(1));
        chk("t3_w0", 0, 64'(log_wd[0][0]), 64'(32'h20220005));
        chk("t3_w1", 0, 64'(log_wd[0][1]), 64'(32'h2043FFFF));
        chk("t3_err", 0, 64'(d0_err), 64'(1));
        chk("t3_count", 0, 64'(d0_cnt), 64'(2 + HALT_EXTRA));

        // 4: six descriptors into a four-word memory (dut1)
        do_start();
        for (int n = 1; n <= 6; n++) send(3, 1, 2, 0, 0, 0, n, 0, n == 6);
        wait_idle();
        chk("t4_writes", 1, 64'(log_n[1]), 64'(4));
        chk("t4_last_addr", 1, 64'(log_ad[1][3]), 64'(19));
        chk("t4_last_word", 1, 64'(log_wd[1][3]), 64'(32'h10220004));
        chk("t4_err", 1, 64'(d1_err), 64'(1));
        chk("t4_done_once", 1, 64'(done_n[1]), 64'(1));
        chk("t4_count", 1, 64'(d1_cnt), 64'(4));

        // 5: reset the cycle after an accept
        do_start();
        send(5, 0, 0, 0, 0, 0, 0, 5, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_kind = 3'd4;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("t5_mem_we", 0, 64'(d0_we), 64'(0));
        chk("t5_busy", 0, 64'(d0_busy), 64'(0));
        chk("t5_count", 0, 64'(d0_cnt), 64'(0));
        chk("t5_wdata", 0, 64'(d0_wdata), 64'(0));
        chk("t5_ready", 0, 64'(d0_ready), 64'(0));
        step();

        // 6: jump at BASE_ADDR=16 (dut1), halt word appended when enabled
        do_start();
        send(5, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        wait_idle();
        chk("t6_a0", 1, 64'(log_ad[1][0]), 64'(16));
        chk("t6_w0", 1, 64'(log_wd[1][0]), 64'(32'h08000000));
        chk("t6_count", 1, 64'(d1_cnt), 64'(1 + HALT_EXTRA));
`ifdef HALT_APPEND_EN
        chk("t6_halt_addr", 1, 64'(log_ad[1][1]), 64'(17));
        chk("t6_halt_word", 1, 64'(log_wd[1][1]), 64'(32'h08000011));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
